// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss BCD stopwatch.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  // Display payload, most significant digit first.
  typedef struct packed {
    bcd_digit_t min_tens;
    bcd_digit_t min_units;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_units;
  } mmss_t;

  localparam bcd_digit_t SEC_UNITS_MAX = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX  = 4'd5;
  localparam bcd_digit_t MIN_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: increments on inc, wraps after WRAP_VALUE, flags the carry.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned WRAP_VALUE = 9
) (
  input  logic       clk_FPGA,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output bcd_digit_t digit,
  output logic       carry_out
);

  localparam bcd_digit_t WRAP = 4'(WRAP_VALUE);

  logic at_wrap;

  assign at_wrap   = (digit == WRAP);
  assign carry_out = inc && at_wrap;

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= at_wrap ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// mm:ss BCD stopwatch counting edges of the divider's slow clock.
// Optional lap freeze of the displayed value: define STOPWATCH_LAP_EN.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MINUTES        = 59,
  parameter int unsigned TICK_ON_BOTH_EDGES = 0
) (
  input  logic       clk_FPGA,
  input  logic       reset,
  input  logic       slow_clock_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       overflow
);

  localparam bcd_digit_t MIN_TENS_MAX  = 4'(MAX_MINUTES / 10);
  localparam bcd_digit_t MIN_UNITS_MAX = 4'(MAX_MINUTES % 10);

  sw_state_t  state, state_d;
  logic       slow_q, ss_q;
  logic       tick_c, ss_edge_c, at_max_c, inc_c, clr_c;
  logic       su_carry, st_carry, mu_carry, unused_mt_carry;
  bcd_digit_t su, st, mu, mt;
  mmss_t      live;

  // Edge registers reset high so a level already high at reset release is not an edge.
  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      slow_q <= 1'b1;
      ss_q   <= 1'b1;
    end else begin
      slow_q <= slow_clock_in;
      ss_q   <= start_stop;
    end
  end

  assign tick_c    = (TICK_ON_BOTH_EDGES != 0) ? (slow_clock_in ^ slow_q)
                                               : (slow_clock_in & ~slow_q);
  assign ss_edge_c = start_stop & ~ss_q;

  assign live     = '{min_tens: mt, min_units: mu, sec_tens: st, sec_units: su};
  assign at_max_c = (mt == MIN_TENS_MAX) && (mu == MIN_UNITS_MAX) &&
                    (st == SEC_TENS_MAX) && (su == SEC_UNITS_MAX);

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      running  <= (state_d == RUN);
      overflow <= (state_d == DONE);
    end
  end

  // Clear beats everything; a tick at the saturation point ends the count instead of wrapping.
  always_comb begin
    state_d = state;
    inc_c   = 1'b0;
    clr_c   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      clr_c   = 1'b1;
    end else begin
      case (state)
        IDLE:    if (ss_edge_c) state_d = RUN;
        RUN: begin
          if (tick_c && at_max_c) begin
            state_d = DONE;
          end else begin
            inc_c = tick_c;
            if (ss_edge_c) state_d = PAUSE;
          end
        end
        PAUSE:   if (ss_edge_c) state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  bcd_digit_counter #(.WRAP_VALUE(int'(SEC_UNITS_MAX))) u_sec_units (
    .clk_FPGA(clk_FPGA), .reset(reset), .inc(inc_c), .clr(clr_c),
    .digit(su), .carry_out(su_carry)
  );

  bcd_digit_counter #(.WRAP_VALUE(int'(SEC_TENS_MAX))) u_sec_tens (
    .clk_FPGA(clk_FPGA), .reset(reset), .inc(su_carry), .clr(clr_c),
    .digit(st), .carry_out(st_carry)
  );

  bcd_digit_counter #(.WRAP_VALUE(int'(MIN_DIGIT_MAX))) u_min_units (
    .clk_FPGA(clk_FPGA), .reset(reset), .inc(st_carry), .clr(clr_c),
    .digit(mu), .carry_out(mu_carry)
  );

  bcd_digit_counter #(.WRAP_VALUE(int'(MIN_DIGIT_MAX))) u_min_tens (
    .clk_FPGA(clk_FPGA), .reset(reset), .inc(mu_carry), .clr(clr_c),
    .digit(mt), .carry_out(unused_mt_carry)
  );

`ifdef STOPWATCH_LAP_EN
  logic  lap_q, lap_hold, lap_edge_c;
  mmss_t snap;

  assign lap_edge_c = lap & ~lap_q;

  // Snapshot is taken on the edge that sets the hold; the live count keeps going underneath.
  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      lap_q    <= 1'b1;
      lap_hold <= 1'b0;
      snap     <= '0;
    end else begin
      lap_q <= lap;
      if (clear) begin
        lap_hold <= 1'b0;
      end else if (lap_edge_c && (state == RUN || state == PAUSE)) begin
        lap_hold <= ~lap_hold;
        if (!lap_hold) snap <= live;
      end
    end
  end

  assign {min_tens, min_units, sec_tens, sec_units} = lap_hold ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign {min_tens, min_units, sec_tens, sec_units} = live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter against a total-seconds reference model.
module tb_stopwatch_bcd_counter;

  localparam int unsigned MAXM     = 1;
  localparam int          MAX_SECS = MAXM * 60 + 59;

  logic       clk_FPGA = 1'b0;
  logic       reset, slow_clock_in, start_stop, clear, lap;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;
  logic       running, overflow;

  always #5 clk_FPGA = ~clk_FPGA;

  stopwatch_bcd_counter #(.MAX_MINUTES(MAXM), .TICK_ON_BOTH_EDGES(0)) dut (
    .clk_FPGA(clk_FPGA), .reset(reset), .slow_clock_in(slow_clock_in),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
    .min_tens(min_tens), .running(running), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_secs;
  logic  m_prev_slow, m_prev_ss;
  logic  cur_slow, cur_ss, lap_v;

  function automatic logic [17:0] exp_vec();
    int s, m;
    s = m_secs % 60;
    m = m_secs / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            m_mode == M_RUN, m_mode == M_DONE};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {min_tens, min_units, sec_tens, sec_units, running, overflow};
  endfunction

  function automatic logic [17:0] mk(int mm, int ss, logic run, logic ovf);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, ovf};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_secs      = 0;
    m_prev_slow = 1'b1;
    m_prev_ss   = 1'b1;
  endtask

  task automatic model_cycle(input logic s, input logic ss, input logic c);
    logic tk, se;
    tk = s & ~m_prev_slow;
    se = ss & ~m_prev_ss;
    m_prev_slow = s;
    m_prev_ss   = ss;
    if (c) begin
      m_mode = M_IDLE;
      m_secs = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (se) m_mode = M_RUN;
        M_RUN: begin
          if (tk) begin
            if (m_secs == MAX_SECS) m_mode = M_DONE;
            else m_secs++;
          end
          if (se && m_mode == M_RUN) m_mode = M_PAUSE;
        end
        M_PAUSE: if (se) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One clk_FPGA cycle: drive, advance the model, compare after the edge.
  task automatic step(input logic s, input logic ss, input logic c);
    slow_clock_in = s;
    start_stop    = ss;
    clear         = c;
    lap           = lap_v;
    cur_slow      = s;
    cur_ss        = ss;
    model_cycle(s, ss, c);
    @(posedge clk_FPGA);
    #1;
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b0, cur_ss, 1'b0);
      step(1'b1, cur_ss, 1'b0);
    end
  endtask

  task automatic ss_pulse();
    step(cur_slow, 1'b0, 1'b0);
    step(cur_slow, 1'b1, 1'b0);
  endtask

  task automatic sync_reset_pulse();
    reset = 1'b1;
    model_reset();
    @(posedge clk_FPGA);
    #1;
    check("in_reset", dut_vec(), 18'h0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; slow_clock_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    lap_v = 1'b0; cur_slow = 1'b0; cur_ss = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_FPGA);
    #1;
    check("reset_state", dut_vec(), 18'h0);
    reset = 1'b0;

    // Start, then 75 seconds.
    ss_pulse();
    ticks(75);
    check("run_01_15", dut_vec(), mk(1, 15, 1'b1, 1'b0));

    // Asynchronous reset between clock edges.
    reset = 1'b1;
    #2;
    check("async_reset", dut_vec(), 18'h0);
    model_reset();
    @(posedge clk_FPGA);
    #1;
    reset = 1'b0;

    // Pause edge and tick in the same cycle: tick counts, then pause.
    ss_pulse();
    ticks(9);
    check("run_00_09", dut_vec(), mk(0, 9, 1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("tick_with_pause", dut_vec(), mk(0, 10, 1'b0, 1'b0));
    ticks(5);
    check("paused_hold", dut_vec(), mk(0, 10, 1'b0, 1'b0));

    // Clear with a coincident start edge in PAUSE; the edge is discarded.
    step(cur_slow, cur_ss, 1'b1);
    ss_pulse();
    ticks(42);
    ss_pulse();
    check("pause_00_42", dut_vec(), mk(0, 42, 1'b0, 1'b0));
    step(cur_slow, 1'b0, 1'b0);
    step(cur_slow, 1'b1, 1'b1);
    check("clear_over_ss", dut_vec(), mk(0, 0, 1'b0, 1'b0));
    step(cur_slow, 1'b1, 1'b0);
    check("ss_not_deferred", dut_vec(), mk(0, 0, 1'b0, 1'b0));
    ss_pulse();
    check("restart_after_clear", dut_vec(), mk(0, 0, 1'b1, 1'b0));

    // Saturation at MAX_MINUTES:59.
    step(cur_slow, cur_ss, 1'b1);
    ss_pulse();
    ticks(119);
    check("reach_01_59", dut_vec(), mk(1, 59, 1'b1, 1'b0));
    ticks(1);
    check("enter_done", dut_vec(), mk(1, 59, 1'b0, 1'b1));
    ticks(10);
    ss_pulse();
    check("done_hold", dut_vec(), mk(1, 59, 1'b0, 1'b1));

    // Slow clock high across reset release is not a tick.
    step(1'b1, 1'b0, 1'b0);
    sync_reset_pulse();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    check("no_tick_after_reset", dut_vec(), mk(0, 0, 1'b1, 1'b0));
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("first_tick", dut_vec(), mk(0, 1, 1'b1, 1'b0));

    // start_stop held high across reset release is not an edge.
    sync_reset_pulse();
    repeat (3) step(cur_slow, 1'b1, 1'b0);
    check("no_ss_after_reset", dut_vec(), mk(0, 0, 1'b0, 1'b0));

    // Randomized traffic; lap wiggles and must not affect the default build.
    for (int i = 0; i < 4000; i++) begin
      logic s, ss, c;
      s  = ($urandom_range(0, 2) == 0) ? ~cur_slow : cur_slow;
      ss = ($urandom_range(0, 39) == 0) ? ~cur_ss : cur_ss;
      c  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) lap_v = ~lap_v;
      step(s, ss, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
